// File: rtl/spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter
//
// Shares one spi_master_4byte instance between N_REQ requesters. A
// round-robin arbiter picks the next requester, latches its word, slave
// index and SPI mode, holds a settle delay when CPOL/CPHA changes, fires a
// single-cycle trigger, waits for the master to finish (or time out) and
// returns the MISO word with a one-hot ack.
//
// Ports
//   CLK_IN       system clock, all logic on the rising edge
//   RESET_N      asynchronous active-low reset
//   req          per-requester request level, held until the matching ack
//   req_din      requester i word at [32i+31:32i]
//   req_target   requester i slave index at [TGT_W*i +: TGT_W]
//   req_cpol     requester i CPOL
//   req_cpha     requester i CPHA
//   ack          one-hot, single-cycle completion strobe to the granted requester
//   rsp_dout     MISO word of the completed transaction, valid with ack
//   rsp_err      high with ack when the transaction timed out
//   busy         high in every state except IDLE
//   spi_din      word handed to the master
//   spi_target   slave index handed to the master
//   spi_cpol     CPOL handed to the master
//   spi_cpha     CPHA handed to the master
//   spi_trigger  single-cycle start pulse to the master
//   spi_dout     MISO word from the master
//   spi_valid    completion level/pulse from the master
// ---------------------------------------------------------------------------
module spi_master_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TGT_W     = 1,
    parameter int SETUP_CYC = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                   CLK_IN,
    input  logic                   RESET_N,
    input  logic [N_REQ-1:0]       req,
    input  logic [32*N_REQ-1:0]    req_din,
    input  logic [TGT_W*N_REQ-1:0] req_target,
    input  logic [N_REQ-1:0]       req_cpol,
    input  logic [N_REQ-1:0]       req_cpha,
    output logic [N_REQ-1:0]       ack,
    output logic [31:0]            rsp_dout,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [31:0]            spi_din,
    output logic [TGT_W-1:0]       spi_target,
    output logic                   spi_cpol,
    output logic                   spi_cpha,
    output logic                   spi_trigger,
    input  logic [31:0]            spi_dout,
    input  logic                   spi_valid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 8;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        TRIG  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rrPtr_q;
    logic [IDX_W-1:0]   grant_q;
    logic [CNT_W-1:0]   setupCnt_q;
    logic [TMO_W-1:0]   tmoCnt_q;
    logic               validPrev_q;

    // Winner of the round-robin search and its request fields.
    logic               winValid_d;
    logic [IDX_W-1:0]   winIdx_d;
    logic [31:0]        winDin_d;
    logic [TGT_W-1:0]   winTgt_d;
    logic               winCpol_d;
    logic               winCpha_d;
    logic               modeDiff_d;
    logic               validRise_d;
    logic [N_REQ-1:0]   grantOneHot_d;

    // Round-robin search: start one past the last granted index and wrap.
    // The first asserted request found wins; later hits are ignored.
    always_comb begin
        int cand;
        cand       = 0;
        winValid_d = 1'b0;
        winIdx_d   = '0;
        winDin_d   = '0;
        winTgt_d   = '0;
        winCpol_d  = 1'b0;
        winCpha_d  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(rrPtr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!winValid_d && req[cand]) begin
                winValid_d = 1'b1;
                winIdx_d   = IDX_W'(cand);
                winDin_d   = req_din[32*cand +: 32];
                winTgt_d   = req_target[TGT_W*cand +: TGT_W];
                winCpol_d  = req_cpol[cand];
                winCpha_d  = req_cpha[cand];
            end
        end
    end

    // The last applied mode is simply what spi_cpol/spi_cpha hold, since
    // those registers keep the previous transaction's mode while idle.
    assign modeDiff_d    = (winCpol_d != spi_cpol) || (winCpha_d != spi_cpha);

    // Only a fresh low-to-high transition of valid counts as completion, so a
    // level left high from an earlier transaction cannot end this one early.
    assign validRise_d   = spi_valid && !validPrev_q;

    assign grantOneHot_d = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;

    // Main controller. Every output is a flop so nothing from req reaches
    // ack or the SPI master combinationally. An asynchronous reset aborts
    // any transaction in flight without an ack.
    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            rrPtr_q     <= IDX_W'(N_REQ - 1);
            grant_q     <= '0;
            setupCnt_q  <= '0;
            tmoCnt_q    <= '0;
            validPrev_q <= 1'b0;
            ack         <= '0;
            rsp_dout    <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            spi_din     <= '0;
            spi_target  <= '0;
            spi_cpol    <= 1'b0;
            spi_cpha    <= 1'b0;
            spi_trigger <= 1'b0;
        end else begin
            validPrev_q <= spi_valid;
            case (state_q)
                IDLE: begin
                    if (winValid_d) begin
                        grant_q    <= winIdx_d;
                        spi_din    <= winDin_d;
                        spi_target <= winTgt_d;
                        spi_cpol   <= winCpol_d;
                        spi_cpha   <= winCpha_d;
                        busy       <= 1'b1;
                        if (modeDiff_d) begin
                            setupCnt_q <= CNT_W'(SETUP_CYC);
                            state_q    <= SETUP;
                        end else begin
                            spi_trigger <= 1'b1;
                            state_q     <= TRIG;
                        end
                    end
                end

                // Holds the new mode on the bus for SETUP_CYC cycles so the
                // clock idle level settles before the master starts.
                SETUP: begin
                    if (setupCnt_q <= CNT_W'(1)) begin
                        spi_trigger <= 1'b1;
                        state_q     <= TRIG;
                    end else begin
                        setupCnt_q <= setupCnt_q - CNT_W'(1);
                    end
                end

                TRIG: begin
                    spi_trigger <= 1'b0;
                    tmoCnt_q    <= '0;
                    state_q     <= WAIT;
                end

                WAIT: begin
                    if (validRise_d) begin
                        rsp_dout <= spi_dout;
                        rsp_err  <= 1'b0;
                        ack      <= grantOneHot_d;
                        state_q  <= DONE;
                    end else if (tmoCnt_q == TMO_W'(TIMEOUT - 1)) begin
                        rsp_dout <= '0;
                        rsp_err  <= 1'b1;
                        ack      <= grantOneHot_d;
                        state_q  <= DONE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + TMO_W'(1);
                    end
                end

                // Ack lasts this one cycle; the next grant can only happen in
                // the following IDLE cycle, so acks never overlap grants.
                DONE: begin
                    ack     <= '0;
                    rsp_err <= 1'b0;
                    rrPtr_q <= grant_q;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_master_arbiter
//
// Directed bench for spi_master_arbiter. Expected completions are queued as
// requests are driven and popped whenever the DUT pulses ack. A small SPI
// master model answers each trigger after a few cycles.
// ---------------------------------------------------------------------------
module tb_spi_master_arbiter;

    localparam int N_REQ     = 4;
    localparam int TGT_W     = 1;
    localparam int SETUP_CYC = 4;
    localparam int TIMEOUT   = 4096;
    localparam logic [31:0] MASK = 32'h5a5a_0f0f;

    logic                   CLK_IN;
    logic                   RESET_N;
    logic [N_REQ-1:0]       req;
    logic [32*N_REQ-1:0]    req_din;
    logic [TGT_W*N_REQ-1:0] req_target;
    logic [N_REQ-1:0]       req_cpol;
    logic [N_REQ-1:0]       req_cpha;
    logic [N_REQ-1:0]       ack;
    logic [31:0]            rsp_dout;
    logic                   rsp_err;
    logic                   busy;
    logic [31:0]            spi_din;
    logic [TGT_W-1:0]       spi_target;
    logic                   spi_cpol;
    logic                   spi_cpha;
    logic                   spi_trigger;
    logic [31:0]            spi_dout;
    logic                   spi_valid;

    spi_master_arbiter #(
        .N_REQ(N_REQ), .TGT_W(TGT_W), .SETUP_CYC(SETUP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_IN(CLK_IN), .RESET_N(RESET_N), .req(req), .req_din(req_din),
        .req_target(req_target), .req_cpol(req_cpol), .req_cpha(req_cpha),
        .ack(ack), .rsp_dout(rsp_dout), .rsp_err(rsp_err), .busy(busy),
        .spi_din(spi_din), .spi_target(spi_target), .spi_cpol(spi_cpol),
        .spi_cpha(spi_cpha), .spi_trigger(spi_trigger), .spi_dout(spi_dout),
        .spi_valid(spi_valid)
    );

    // Free-running 10-unit clock.
    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        int          idx;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] replyQ[$];

    int checks = 0;
    int passed = 0;
    int cycle  = 0;
    int ackCount = 0;
    int lastAckCycle = 0;
    int trigCount = 0;
    int trigCycle = 0;
    int trigDouble = 0;
    int busyRiseCycle = 0;
    logic [31:0] trigDin;
    logic [TGT_W-1:0] trigTgt;
    logic [1:0]  trigMode;
    logic [31:0] setupDin;
    logic [1:0]  setupMode;
    logic        prevTrig = 1'b0;
    logic        prevBusy = 1'b0;
    bit          autoResp = 1'b1;
    bit          holdReq  = 1'b0;
    int          respCnt  = 0;
    logic [31:0] respWord = '0;

    // One comparison: counts it, asserts equality, reports on failure.
    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Pops the scoreboard on every ack and compares index, data and error.
    task automatic checkOutput();
        exp_t e;
        logic [N_REQ-1:0] expAck;
        if (ack !== '0) begin
            ackCount++;
            lastAckCycle = cycle;
            expectEq("ack_onehot", 32'($onehot(ack)), 32'd1);
            if (expQ.size() == 0) begin
                expectEq("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = expQ.pop_front();
                expAck = {{(N_REQ-1){1'b0}}, 1'b1} << e.idx;
                expectEq("ack_index", 32'(ack), 32'(expAck));
                expectEq("rsp_dout", rsp_dout, e.dout);
                expectEq("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            if (!holdReq) req = req & ~ack;
        end
    endtask

    // Advances one cycle, samples on the falling edge, and runs the master model.
    task automatic tick();
        @(negedge CLK_IN);
        cycle++;
        if (busy && !prevBusy) begin
            busyRiseCycle = cycle;
            setupDin  = spi_din;
            setupMode = {spi_cpol, spi_cpha};
        end
        if (spi_trigger) begin
            trigCount++;
            trigCycle = cycle;
            trigDin   = spi_din;
            trigTgt   = spi_target;
            trigMode  = {spi_cpol, spi_cpha};
            if (prevTrig) trigDouble++;
        end
        prevTrig = spi_trigger;
        prevBusy = busy;
        checkOutput();
        if (autoResp) begin
            spi_valid = 1'b0;
            if (respCnt > 0) begin
                respCnt--;
                if (respCnt == 0) begin
                    spi_dout  = respWord;
                    spi_valid = 1'b1;
                end
            end
            if (spi_trigger) begin
                respCnt = 3;
                if (replyQ.size() > 0) respWord = replyQ.pop_front();
                else respWord = spi_din ^ MASK;
            end
        end
    endtask

    // Drives requester idx's fields, raises its req, optionally queues the expectation.
    task automatic applyStimulus(input int idx, input logic [31:0] din, input logic [TGT_W-1:0] tgt,
                                 input logic cpol, input logic cpha,
                                 input logic [31:0] expDout, input logic expErr, input bit push);
        req_din[32*idx +: 32]          = din;
        req_target[TGT_W*idx +: TGT_W] = tgt;
        req_cpol[idx] = cpol;
        req_cpha[idx] = cpha;
        req[idx]      = 1'b1;
        if (push) expQ.push_back('{idx, expDout, expErr});
    endtask

    task automatic pushExpect(input int idx, input logic [31:0] dout, input logic err);
        expQ.push_back('{idx, dout, err});
    endtask

    task automatic waitAcks(input int n, input int budget, input bit dropAll, input string tag);
        int target;
        target = ackCount + n;
        for (int i = 0; i < budget && ackCount < target; i++) begin
            tick();
            if (dropAll && ackCount == target) req = '0;
        end
        expectEq({tag, "_acks"}, 32'(ackCount), 32'(target));
    endtask

    task automatic waitTrigger(input int budget, input string tag);
        int target;
        target = trigCount + 1;
        for (int i = 0; i < budget && trigCount < target; i++) tick();
        expectEq({tag, "_trig"}, 32'(trigCount), 32'(target));
    endtask

    initial begin
        int trigBefore;
        int lat;
        RESET_N    = 1'b0;
        req        = '0;
        req_din    = '0;
        req_target = '0;
        req_cpol   = '0;
        req_cpha   = '0;
        spi_dout   = '0;
        spi_valid  = 1'b0;

        // Reset state
        tick(); tick();
        expectEq("rst_busy", 32'(busy), 32'd0);
        expectEq("rst_trigger", 32'(spi_trigger), 32'd0);
        expectEq("rst_ack", 32'(ack), 32'd0);
        expectEq("rst_spi_din", spi_din, 32'd0);
        expectEq("rst_misc", 32'({rsp_err, spi_cpol, spi_cpha, spi_target}), 32'd0);
        expectEq("rst_rsp_dout", rsp_dout, 32'd0);
        RESET_N = 1'b1;
        tick();

        // Single request, reset mode matches: no settle delay
        $display("[TB] single request");
        trigBefore = trigCount;
        replyQ.push_back(32'h1234_5678);
        applyStimulus(0, 32'haaaa_3333, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        waitAcks(1, 50, 1'b0, "single");
        expectEq("single_trig_count", 32'(trigCount - trigBefore), 32'd1);
        expectEq("single_no_setup", 32'(trigCycle - busyRiseCycle), 32'd0);
        expectEq("single_spi_din", trigDin, 32'haaaa_3333);
        expectEq("single_spi_target", 32'(trigTgt), 32'd1);

        // Mode change inserts SETUP_CYC stable cycles before trigger
        $display("[TB] mode change");
        tick();
        applyStimulus(1, 32'hcccc_5555, 1'b0, 1'b1, 1'b1, 32'hcccc_5555 ^ MASK, 1'b0, 1'b1);
        waitAcks(1, 50, 1'b0, "modechg");
        expectEq("modechg_setup_len", 32'(trigCycle - busyRiseCycle), 32'(SETUP_CYC));
        expectEq("modechg_setup_mode", 32'(setupMode), 32'd3);
        expectEq("modechg_setup_din", setupDin, 32'hcccc_5555);
        expectEq("modechg_trig_mode", 32'(trigMode), 32'd3);
        expectEq("modechg_trig_din", trigDin, 32'hcccc_5555);
        tick();
        applyStimulus(1, 32'h0123_4567, 1'b1, 1'b1, 1'b1, 32'h0123_4567 ^ MASK, 1'b0, 1'b1);
        waitAcks(1, 50, 1'b0, "samemode");
        expectEq("samemode_no_setup", 32'(trigCycle - busyRiseCycle), 32'd0);
        tick();
        expectEq("mode_hold", 32'({spi_cpol, spi_cpha}), 32'd3);
        expectEq("idle_busy", 32'(busy), 32'd0);

        // Requester 3 so the rotation below starts at requester 0
        applyStimulus(3, 32'h3333_0003, 1'b0, 1'b1, 1'b1, 32'h3333_0003 ^ MASK, 1'b0, 1'b1);
        waitAcks(1, 50, 1'b0, "req3");
        tick();

        // Round robin with every request held
        $display("[TB] round robin");
        holdReq = 1'b1;
        for (int i = 0; i < N_REQ; i++)
            applyStimulus(i, 32'h1000_0000 + 32'(i), 1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0);
        pushExpect(0, 32'h1000_0000 ^ MASK, 1'b0);
        pushExpect(1, 32'h1000_0001 ^ MASK, 1'b0);
        pushExpect(2, 32'h1000_0002 ^ MASK, 1'b0);
        pushExpect(3, 32'h1000_0003 ^ MASK, 1'b0);
        pushExpect(0, 32'h1000_0000 ^ MASK, 1'b0);
        pushExpect(1, 32'h1000_0001 ^ MASK, 1'b0);
        waitAcks(6, 200, 1'b1, "rr");
        holdReq = 1'b0;
        tick(); tick(); tick();
        expectEq("rr_busy_after", 32'(busy), 32'd0);
        expectEq("rr_queue_drained", 32'(expQ.size()), 32'd0);

        // Timeout: master never answers
        $display("[TB] timeout");
        autoResp  = 1'b0;
        spi_valid = 1'b0;
        applyStimulus(2, 32'h0bad_f00d, 1'b0, 1'b1, 1'b1, 32'd0, 1'b1, 1'b1);
        waitAcks(1, TIMEOUT + 100, 1'b0, "timeout");
        lat = lastAckCycle - trigCycle;
        expectEq("timeout_latency", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 2), 32'd1);
        autoResp = 1'b1;
        tick();
        applyStimulus(3, 32'h1357_2468, 1'b1, 1'b1, 1'b1, 32'h1357_2468 ^ MASK, 1'b0, 1'b1);
        waitAcks(1, 50, 1'b0, "after_timeout");

        // Stale valid: high across TRIG must not complete the transaction
        $display("[TB] stale valid");
        tick();
        autoResp  = 1'b0;
        spi_dout  = 32'hbad0_bad0;
        spi_valid = 1'b1;
        applyStimulus(0, 32'h7777_0000, 1'b0, 1'b1, 1'b1, 32'hdddd_6666, 1'b0, 1'b1);
        waitTrigger(20, "stale");
        tick(); tick(); tick();
        spi_valid = 1'b0;
        tick(); tick();
        spi_dout  = 32'hdddd_6666;
        spi_valid = 1'b1;
        waitAcks(1, 20, 1'b0, "stale");
        spi_valid = 1'b0;
        autoResp  = 1'b1;
        tick();

        // Reset during WAIT aborts without ack; pending req0 wins afterwards
        $display("[TB] reset during wait");
        autoResp = 1'b0;
        applyStimulus(0, 32'h2468_ace0, 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0);
        waitTrigger(20, "rstwait");
        tick(); tick(); tick();
        RESET_N = 1'b0;
        #1;
        expectEq("rstwait_busy", 32'(busy), 32'd0);
        expectEq("rstwait_trigger", 32'(spi_trigger), 32'd0);
        expectEq("rstwait_spi_din", spi_din, 32'd0);
        expectEq("rstwait_misc", 32'({ack, rsp_err, spi_cpol, spi_cpha, spi_target}), 32'd0);
        tick(); tick(); tick();
        RESET_N = 1'b1;
        autoResp = 1'b1;
        pushExpect(0, 32'h2468_ace0 ^ MASK, 1'b0);
        applyStimulus(2, 32'h8642_0000, 1'b0, 1'b1, 1'b1, 32'h8642_0000 ^ MASK, 1'b0, 1'b1);
        waitAcks(2, 100, 1'b0, "rstwait_regrant");

        tick(); tick();
        expectEq("scoreboard_empty", 32'(expQ.size()), 32'd0);
        expectEq("trigger_width", 32'(trigDouble), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master_4byte instance among N_REQ requesters (config sequencer, ADC readout, DAC writer, etc.).
- Arbitrates round-robin and latches the winner's word, slave select and mode (CPOL/CPHA).
- Applies a mode-settle delay when the mode changes, fires a single-cycle trigger, waits for completion, and returns dout with a one-hot ack.
- Sits directly between requester logic and the SPI master on the CLK_IN domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
TGT_W, 1, width of the SPI master target/slave-select index
SETUP_CYC, 4, idle cycles held after a CPOL/CPHA change before trigger (1..255)
TIMEOUT, 4096, max cycles from trigger to valid before abort (>=64)

Ports:
CLK_IN  input  1  system clock, all logic rising-edge
RESET_N  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request level, held until matching ack
req_din  input  32*N_REQ  requester i word at [32i+31:32i]
req_target  input  TGT_W*N_REQ  requester i slave index at [TGT_W*i+:TGT_W]
req_cpol  input  N_REQ  requester i CPOL
req_cpha  input  N_REQ  requester i CPHA
ack  output  N_REQ  one-hot, 1-cycle completion strobe to the granted requester
rsp_dout  output  32  MISO word of the completed transaction, valid with ack
rsp_err  output  1  high with ack when the transaction timed out
busy  output  1  high in any state except IDLE
spi_din  output  32  to master din
spi_target  output  TGT_W  to master target
spi_cpol  output  1  to master CPOL
spi_cpha  output  1  to master CPHA
spi_trigger  output  1  to master trigger
spi_dout  input  32  from master dout
spi_valid  input  1  from master valid

Behaviour:
- Reset (RESET_N low, async): state=IDLE. All outputs 0. rr_ptr=N_REQ-1. mode_init=0. The last applied mode clears to CPOL=0, CPHA=0.
- Reset mid-transaction: abort immediately and de-assert spi_trigger. No ack is issued. Requesters must re-request.
- Registered outputs only. No combinational path from req to ack or spi_*.
- FSM states: IDLE, SETUP, TRIG, WAIT, DONE.
- IDLE:
  - If |req, grant the first asserted index searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
  - Latch that requester's din, target, cpol and cpha onto spi_din, spi_target, spi_cpol and spi_cpha.
  - If the mode differs from the last applied mode: load cnt=SETUP_CYC and go to SETUP. Otherwise go to TRIG.
- SETUP: decrement cnt each cycle; go to TRIG when cnt reaches 1. spi_* stay stable.
- TRIG: spi_trigger=1 for exactly this one cycle. Clear the timeout counter and go to WAIT.
- WAIT:
  - Completion is a rising edge of spi_valid (registered prev=0, current=1) seen in WAIT. A level already high at TRIG does not count.
  - On that edge, capture spi_dout into rsp_dout and go to DONE.
  - If the counter reaches TIMEOUT first, set the error flag, set rsp_dout=0 and go to DONE.
- DONE:
  - ack[grant]=1 and rsp_err=error flag for one cycle.
  - rr_ptr=grant. Clear the error flag and go to IDLE.
  - Earliest next grant is the following cycle, so ack and the next grant never overlap.
- Latency with the mode unchanged: grant cycle→TRIG is 1 cycle. With a mode change it is SETUP_CYC+1 cycles.
- Requester rules:
  - req_* fields are sampled only at grant. Later changes are ignored for the current transaction.
  - Dropping req after grant does not cancel: the transaction completes and ack is still pulsed.
  - A req still high in the cycle after its ack is a new request.
- Fairness: with all requesters asserted continuously, grants go in strict rotation. Each requester waits at most N_REQ-1 transactions.
- spi_din, spi_target, spi_cpol and spi_cpha hold their values after DONE until the next grant, so the bus idle level stays in the last mode.

Test Plan:
- Single request: req=0001, din0=32'haaaa3333, target0=1, mode 0/0. Master pulses valid with dout=32'h12345678 → exactly one spi_trigger cycle, ack=0001, rsp_dout=32'h12345678, rsp_err=0, no SETUP (mode matched reset mode).
- Mode change: req1 with CPOL=1, CPHA=1, din=32'hcccc5555 → spi_cpol/spi_cpha change, then exactly SETUP_CYC(4) cycles of stable spi_* before spi_trigger. A following req1 with the same mode triggers 1 cycle after grant.
- Round robin: req=1111 held continuously → ack order 0,1,2,3,0,1. Never two acks in one cycle. busy drops only when req=0000.
- Timeout: spi_valid tied 0 → ack after trigger+TIMEOUT (4096) cycles with rsp_err=1 and rsp_dout=0. The next request proceeds normally.
- Stale valid: spi_valid held high across TRIG, falls, then rises with dout=32'hdddd6666 → completion only on the later rising edge, rsp_dout=32'hdddd6666.
- Reset during WAIT: RESET_N low for 3 cycles → all outputs 0 immediately, no ack. After release, the pending req0 is regranted first (rr_ptr=N_REQ-1).
